// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with write-to-read bypass,
// per-register pending scoreboard and a sequential clear engine.
module regfile_sb #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic [DATA_WIDTH-1:0] r1,
    output logic [DATA_WIDTH-1:0] r2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic                  iss_en,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  any_pending
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      pend;
    logic                  we, ie, z1, z2, b1, b2;

    assign we = wr_en && state == IDLE && !(ZERO_REG != 0 && rd == '0);
    assign ie = iss_en && state == IDLE && !(ZERO_REG != 0 && iss_rd == '0);

    // Zero register dominates the bypass; bypass only while writes are accepted.
    assign z1 = ZERO_REG != 0 && rs1 == '0;
    assign z2 = ZERO_REG != 0 && rs2 == '0;
    assign b1 = BYPASS != 0 && wr_en && state == IDLE && rd == rs1;
    assign b2 = BYPASS != 0 && wr_en && state == IDLE && rd == rs2;

    assign r1          = z1 ? '0 : b1 ? d_in : mem[rs1];
    assign r2          = z2 ? '0 : b2 ? d_in : mem[rs2];
    assign rs1_busy    = !z1 && !b1 && pend[rs1];
    assign rs2_busy    = !z2 && !b2 && pend[rs2];
    assign any_pending = |pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            clr_busy <= 1'b0;
            pend     <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == CLEAR) begin
            mem[idx]  <= '0;
            pend[idx] <= 1'b0;
            idx       <= idx + 1'b1;
            if (&idx) begin
                state    <= IDLE;
                clr_busy <= 1'b0;
            end
        end else begin
            if (we) begin
                mem[rd]  <= d_in;
                pend[rd] <= 1'b0;
            end
            // Issue is applied after the write so a same-index issue wins.
            if (ie) pend[iss_rd] <= 1'b1;
            if (clr_req) begin
                state    <= CLEAR;
                idx      <= '0;
                clr_busy <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: two configurations (16x8 zero-reg/bypass, 32x16 plain) driven
// by shared stimulus and compared every cycle against an array-based model.
module tb_regfile_sb;
    logic        clk, rst, wr_en, iss_en, clr_req;
    logic [3:0]  rs1, rs2, rd, iss_rd;
    logic [31:0] d_in;

    logic [15:0] a_r1, a_r2;
    logic [31:0] b_r1, b_r2;
    logic        a_b1, a_b2, a_cb, a_any, b_b1, b_b2, b_cb, b_any;

    int tests = 0;
    int fails = 0;
    bit chk_on = 0;

    regfile_sb u0 (
        .clk(clk), .rst(rst), .rs1(rs1[2:0]), .rs2(rs2[2:0]), .r1(a_r1), .r2(a_r2),
        .rs1_busy(a_b1), .rs2_busy(a_b2), .wr_en(wr_en), .rd(rd[2:0]), .d_in(d_in[15:0]),
        .iss_en(iss_en), .iss_rd(iss_rd[2:0]), .clr_req(clr_req), .clr_busy(a_cb),
        .any_pending(a_any)
    );

    regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ZERO_REG(0), .BYPASS(0)) u1 (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .r1(b_r1), .r2(b_r2),
        .rs1_busy(b_b1), .rs2_busy(b_b2), .wr_en(wr_en), .rd(rd), .d_in(d_in),
        .iss_en(iss_en), .iss_rd(iss_rd), .clr_req(clr_req), .clr_busy(b_cb),
        .any_pending(b_any)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Model: plain storage arrays plus "edges into the clear" (0 = idle).
    logic [31:0] m [2][16];
    logic        p [2][16];
    int          cn [2];

    function automatic int dep(int i);
        return i == 0 ? 8 : 16;
    endfunction
    function automatic bit zr(int i);
        return i == 0;
    endfunction
    function automatic bit bp(int i);
        return i == 0;
    endfunction
    function automatic logic [31:0] msk(int i);
        return i == 0 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction
    function automatic int ix(int i, logic [3:0] a);
        return int'(a) % dep(i);
    endfunction
    function automatic bit byp(int i, logic [3:0] s);
        return bp(i) && wr_en && cn[i] == 0 && ix(i, rd) == ix(i, s);
    endfunction
    function automatic logic [31:0] exp_r(int i, logic [3:0] s);
        if (zr(i) && ix(i, s) == 0) return 32'h0;
        if (byp(i, s)) return d_in & msk(i);
        return m[i][ix(i, s)];
    endfunction
    function automatic logic [31:0] exp_busy(int i, logic [3:0] s);
        return 32'((!(zr(i) && ix(i, s) == 0)) && !byp(i, s) && p[i][ix(i, s)]);
    endfunction
    function automatic logic [31:0] exp_any(int i);
        bit o = 0;
        for (int k = 0; k < dep(i); k++) o = o | p[i][k];
        return 32'(o);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int k = 0; k < 16; k++) begin
                    m[i][k] <= '0;
                    p[i][k] <= 1'b0;
                end
                cn[i] <= 0;
            end else if (cn[i] != 0) begin
                m[i][cn[i]-1] <= '0;
                p[i][cn[i]-1] <= 1'b0;
                cn[i] <= (cn[i] == dep(i)) ? 0 : cn[i] + 1;
            end else begin
                if (wr_en && !(zr(i) && ix(i, rd) == 0)) begin
                    m[i][ix(i, rd)] <= d_in & msk(i);
                    p[i][ix(i, rd)] <= 1'b0;
                end
                if (iss_en && !(zr(i) && ix(i, iss_rd) == 0)) p[i][ix(i, iss_rd)] <= 1'b1;
                if (clr_req) cn[i] <= 1;
            end
        end
    end

    task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
        end
    endtask

    logic [31:0] g_r1 [2], g_r2 [2];
    logic [1:0]  g_b1, g_b2, g_cb, g_any;
    assign g_r1[0] = 32'(a_r1);
    assign g_r1[1] = b_r1;
    assign g_r2[0] = 32'(a_r2);
    assign g_r2[1] = b_r2;
    assign g_b1  = {b_b1, a_b1};
    assign g_b2  = {b_b2, a_b2};
    assign g_cb  = {b_cb, a_cb};
    assign g_any = {b_any, a_any};

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("u%0d.r1", i), g_r1[i], exp_r(i, rs1));
                chk($sformatf("u%0d.r2", i), g_r2[i], exp_r(i, rs2));
                chk($sformatf("u%0d.rs1_busy", i), 32'(g_b1[i]), exp_busy(i, rs1));
                chk($sformatf("u%0d.rs2_busy", i), 32'(g_b2[i]), exp_busy(i, rs2));
                chk($sformatf("u%0d.clr_busy", i), 32'(g_cb[i]), 32'(cn[i] != 0));
                chk($sformatf("u%0d.any_pending", i), 32'(g_any[i]), exp_any(i));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; wr_en = 0; iss_en = 0; clr_req = 0;
        rs1 = 0; rs2 = 0; rd = 0; iss_rd = 0; d_in = 0;
        cyc(); cyc();
        rst = 0; chk_on = 1;
        #1;
        chk("reset clr_busy", 32'({b_cb, a_cb}), 32'h0);
        chk("reset any_pending", 32'({b_any, a_any}), 32'h0);
        for (int k = 0; k < 8; k++) begin
            rs1 = 4'(k); rs2 = 4'(7 - k);
            #1;
            chk("reset read", 32'(a_r1) | 32'(a_r2) | b_r1, 32'h0);
            chk("reset busy", 32'({a_b1, a_b2, b_b1, b_b2}), 32'h0);
            cyc();
        end
        // write and bypass
        wr_en = 1; rd = 5; d_in = 32'h0000_BEEF; rs1 = 5;
        #1;
        chk("bypass a_r1", 32'(a_r1), 32'h0000_BEEF);
        chk("no-bypass b_r1", b_r1, 32'h0);
        cyc();
        wr_en = 0;
        #1;
        chk("stored a_r1", 32'(a_r1), 32'h0000_BEEF);
        chk("stored b_r1", b_r1, 32'h0000_BEEF);
        // zero register
        wr_en = 1; rd = 0; d_in = 32'h0000_1234; rs1 = 0;
        #1;
        chk("zero bypass a_r1", 32'(a_r1), 32'h0);
        cyc();
        wr_en = 0;
        #1;
        chk("zero a_r1", 32'(a_r1), 32'h0);
        chk("reg0 b_r1", b_r1, 32'h0000_1234);
        // issue, writeback, issue+write
        iss_en = 1; iss_rd = 3; rs2 = 3;
        #1;
        chk("busy before issue edge", 32'(a_b2), 32'h0);
        cyc();
        iss_en = 0;
        #1;
        chk("busy after issue", 32'(a_b2), 32'h1);
        chk("any after issue", 32'(a_any), 32'h1);
        wr_en = 1; rd = 3; d_in = 32'h0000_3333;
        #1;
        chk("writeback bypass busy", 32'(a_b2), 32'h0);
        chk("writeback no-bypass busy", 32'(b_b2), 32'h1);
        cyc();
        wr_en = 0;
        #1;
        chk("any after writeback", 32'({b_any, a_any}), 32'h0);
        wr_en = 1; iss_en = 1; rd = 3; iss_rd = 3; d_in = 32'h0000_4444;
        cyc();
        wr_en = 0; iss_en = 0;
        #1;
        chk("issue wins busy", 32'(a_b2), 32'h1);
        chk("issue+write data", 32'(a_r2), 32'h0000_4444);
        // fill then clear
        for (int k = 1; k < 8; k++) begin
            wr_en = 1; rd = 4'(k); d_in = 32'(k) * 32'h1111;
            cyc();
        end
        wr_en = 0;
        clr_req = 1;
        cyc();
        clr_req = 0;
        for (int j = 1; j <= 16; j++) begin
            #1;
            chk($sformatf("clear a_clr_busy j=%0d", j), 32'(a_cb), 32'(j <= 8));
            chk($sformatf("clear b_clr_busy j=%0d", j), 32'(b_cb), 32'h1);
            if (j >= 2 && j <= 8) begin
                rs1 = (j == 6) ? 4'd2 : 4'(j - 2);
                rs2 = 4'(j - 1);
                if (j == 6) begin
                    wr_en = 1; rd = 2; d_in = 32'h0000_AAAA;
                end
                #1;
                chk($sformatf("cleared a_r1 j=%0d", j), 32'(a_r1), 32'h0);
                if (j >= 3) chk($sformatf("uncleared a_r2 j=%0d", j), 32'(a_r2), 32'(j - 1) * 32'h1111);
            end
            cyc();
            wr_en = 0;
        end
        #1;
        chk("clear done", 32'({b_cb, a_cb}), 32'h0);
        for (int k = 0; k < 16; k++) begin
            rs1 = 4'(k); rs2 = 4'(15 - k);
            #1;
            chk("post-clear read", 32'(a_r1) | b_r1 | b_r2, 32'h0);
            cyc();
        end
        // reset mid-clear
        for (int k = 1; k < 4; k++) begin
            wr_en = 1; rd = 4'(k); d_in = 32'h5A5A_0000 + 32'(k);
            cyc();
        end
        wr_en = 0; clr_req = 1;
        cyc();
        clr_req = 0;
        cyc(); cyc(); cyc();
        rst = 1;
        cyc();
        rst = 0;
        #1;
        chk("rst mid-clear clr_busy", 32'({b_cb, a_cb}), 32'h0);
        for (int k = 0; k < 8; k++) begin
            rs1 = 4'(k);
            #1;
            chk("rst mid-clear read", 32'(a_r1) | b_r1, 32'h0);
        end
        rst = 1; clr_req = 1;
        cyc();
        rst = 0; clr_req = 0;
        #1;
        chk("rst+clr_req idle", 32'({b_cb, a_cb}), 32'h0);
        // wide config, register 0 is ordinary
        wr_en = 1; rd = 0; d_in = 32'hDEAD_BEEF;
        cyc();
        wr_en = 0; rs1 = 0;
        #1;
        chk("wide reg0", b_r1, 32'hDEAD_BEEF);
        chk("narrow reg0", 32'(a_r1), 32'h0);
        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            rst     = ($urandom_range(0, 249) == 0);
            clr_req = ($urandom_range(0, 59) == 0);
            wr_en   = $urandom_range(0, 1) == 1;
            iss_en  = ($urandom_range(0, 9) < 4);
            rd      = 4'($urandom_range(0, 15));
            iss_rd  = ($urandom_range(0, 3) == 0) ? rd : 4'($urandom_range(0, 15));
            rs1     = ($urandom_range(0, 2) == 0) ? rd : 4'($urandom_range(0, 15));
            rs2     = ($urandom_range(0, 2) == 0) ? iss_rd : 4'($urandom_range(0, 15));
            d_in    = $urandom;
            cyc();
        end
        rst = 0; wr_en = 0; iss_en = 0; clr_req = 0;
        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
